// File: rtl/inst_fetch_stage.sv
// Fetch stage: 32-bit pc, 1-cycle fetch-to-decode register, priority halt > flush > stall > advance.
// Optional perf counters (cnt_cycle/cnt_stall/cnt_flush) when FETCH_PERF_COUNTER_EN is defined.
module inst_fetch_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    input  logic        resume,
    output logic [9:0]  imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] id_inst,
    output logic [5:0]  id_opcode,
    output logic [4:0]  id_rt,
    output logic [5:0]  id_funct,
    output logic [31:0] id_pc4,
    output logic        id_valid,
    output logic        halted
`ifdef FETCH_PERF_COUNTER_EN
    ,
    output logic [31:0] cnt_cycle,
    output logic [31:0] cnt_stall,
    output logic [31:0] cnt_flush
`endif
);

    typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_id_inst;
    logic [31:0] r_id_pc4;
    logic        r_id_valid;

    logic        w_do_halt;
    logic        w_do_flush;
    logic        w_do_stall;
    logic        w_do_adv;
    logic [31:0] w_pc4;

    assign w_pc4 = r_pc + 32'd4;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:    if (halt)   w_state_nxt = ST_HALTED;
            ST_HALTED: if (resume) w_state_nxt = ST_RUN;
            default:   w_state_nxt = ST_RUN;
        endcase
    end

    // Output/control decode; everything is a no-op while halted, including the resume cycle
    always_comb begin
        w_do_halt  = 1'b0;
        w_do_flush = 1'b0;
        w_do_stall = 1'b0;
        w_do_adv   = 1'b0;
        if (r_state == ST_RUN) begin
            if (halt)       w_do_halt  = 1'b1;
            else if (flush) w_do_flush = 1'b1;
            else if (stall) w_do_stall = 1'b1;
            else            w_do_adv   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= 32'h0000_0000;
            r_id_inst  <= 32'h0000_0000;
            r_id_pc4   <= 32'h0000_0000;
            r_id_valid <= 1'b0;
        end else if (w_do_adv) begin
            r_pc       <= w_pc4;
            r_id_inst  <= imem_data;
            r_id_pc4   <= w_pc4;
            r_id_valid <= 1'b1;
        end else if (w_do_flush) begin
            r_pc       <= redirect_pc;
            r_id_inst  <= 32'h0000_0000;
            r_id_valid <= 1'b0;
        end else if (w_do_halt) begin
            r_id_inst  <= 32'h0000_0000;
            r_id_valid <= 1'b0;
        end
    end

    assign imem_addr = r_pc[11:2];
    assign id_inst   = r_id_inst;
    assign id_opcode = r_id_inst[31:26];
    assign id_rt     = r_id_inst[20:16];
    assign id_funct  = r_id_inst[5:0];
    assign id_pc4    = r_id_pc4;
    assign id_valid  = r_id_valid;
    assign halted    = (r_state == ST_HALTED);

`ifdef FETCH_PERF_COUNTER_EN
    logic [31:0] r_cnt_cycle;
    logic [31:0] r_cnt_stall;
    logic [31:0] r_cnt_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_cycle <= 32'd0;
            r_cnt_stall <= 32'd0;
            r_cnt_flush <= 32'd0;
        end else begin
            if (r_state == ST_RUN) r_cnt_cycle <= r_cnt_cycle + 32'd1;
            if (w_do_stall)        r_cnt_stall <= r_cnt_stall + 32'd1;
            if (w_do_flush)        r_cnt_flush <= r_cnt_flush + 32'd1;
        end
    end

    assign cnt_cycle = r_cnt_cycle;
    assign cnt_stall = r_cnt_stall;
    assign cnt_flush = r_cnt_flush;
`endif

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Scoreboarded bench for inst_fetch_stage: driver pushes expected state, monitor pops and compares.
module tb_inst_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        resume;
    logic [9:0]  imem_addr;
    logic [31:0] imem_data;
    logic [31:0] id_inst;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rt;
    logic [5:0]  id_funct;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic        halted;
`ifdef FETCH_PERF_COUNTER_EN
    logic [31:0] cnt_cycle;
    logic [31:0] cnt_stall;
    logic [31:0] cnt_flush;
`endif

    logic [31:0] imem [0:1023];
    assign imem_data = imem[imem_addr];

    inst_fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .redirect_pc(redirect_pc), .halt(halt), .resume(resume),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .id_inst(id_inst), .id_opcode(id_opcode), .id_rt(id_rt), .id_funct(id_funct),
        .id_pc4(id_pc4), .id_valid(id_valid), .halted(halted)
`ifdef FETCH_PERF_COUNTER_EN
        , .cnt_cycle(cnt_cycle), .cnt_stall(cnt_stall), .cnt_flush(cnt_flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc4;
        logic        valid;
        logic        hlt;
        logic [9:0]  addr;
        logic [31:0] cc;
        logic [31:0] cs;
        logic [31:0] cf;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc, m_inst, m_pc4;
    logic        m_valid, m_halted;
    logic [31:0] m_cc, m_cs, m_cf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model per the fetch rules, queue the result.
    task automatic step(input logic r, input logic s, input logic f, input logic [31:0] rp,
                        input logic h, input logic rs);
        exp_t e;
        @(negedge clk);
        rst = r; stall = s; flush = f; redirect_pc = rp; halt = h; resume = rs;
        if (r) begin
            m_pc = 0; m_inst = 0; m_pc4 = 0; m_valid = 0; m_halted = 0;
            m_cc = 0; m_cs = 0; m_cf = 0;
        end else if (m_halted) begin
            if (rs) m_halted = 0;
        end else begin
            m_cc = m_cc + 1;
            if (h) begin
                m_halted = 1; m_inst = 0; m_valid = 0;
            end else if (f) begin
                m_pc = rp; m_inst = 0; m_valid = 0; m_cf = m_cf + 1;
            end else if (s) begin
                m_cs = m_cs + 1;
            end else begin
                m_inst = imem[m_pc[11:2]];
                m_pc = m_pc + 4;
                m_pc4 = m_pc;
                m_valid = 1;
            end
        end
        e.inst = m_inst; e.pc4 = m_pc4; e.valid = m_valid; e.hlt = m_halted;
        e.addr = m_pc[11:2]; e.cc = m_cc; e.cs = m_cs; e.cf = m_cf;
        q.push_back(e);
    endtask

    task automatic adv(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 0, 0);
    endtask

    // Monitor: outputs settle 1 time unit after each rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("id_inst",   id_inst, e.inst);
                chk("id_pc4",    id_pc4, e.pc4);
                chk("id_valid",  32'(id_valid), 32'(e.valid));
                chk("halted",    32'(halted), 32'(e.hlt));
                chk("imem_addr", 32'(imem_addr), 32'(e.addr));
                chk("id_opcode", 32'(id_opcode), 32'(e.inst[31:26]));
                chk("id_rt",     32'(id_rt), 32'(e.inst[20:16]));
                chk("id_funct",  32'(id_funct), 32'(e.inst[5:0]));
`ifdef FETCH_PERF_COUNTER_EN
                chk("cnt_cycle", cnt_cycle, e.cc);
                chk("cnt_stall", cnt_stall, e.cs);
                chk("cnt_flush", cnt_flush, e.cf);
`endif
            end
        end
    end

    initial begin
        rst = 1; stall = 0; flush = 0; redirect_pc = 0; halt = 0; resume = 0;
        for (int k = 0; k < 1024; k++) imem[k] = 32'(k + 1);

        // Reset then free run: id_inst 1,2,3 / id_pc4 4,8,12
        step(1, 0, 0, 0, 0, 0);
        adv(3);

        // Stall two cycles at pc=8, then resume fetching word 2
        step(1, 0, 0, 0, 0, 0);
        adv(2);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        adv(2);

        // Flush together with stall: bubble, imem_addr = 0x10
        step(0, 1, 1, 32'h40, 0, 0);
        adv(2);

        // Halt with flush: redirect dropped, halted state ignores controls, resume fetches held pc
        step(0, 0, 1, 32'h200, 1, 0);
        step(0, 1, 1, 32'h300, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        adv(2);

        // pc wrap: 0xFFFFFFFC -> 0, id_pc4 = 0, imem_addr 0x3FF -> 0
        step(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        adv(2);

        // Reset in the middle of a halt
        step(0, 0, 0, 0, 1, 0);
        step(1, 1, 1, 32'h80, 1, 0);
        adv(1);

        // 10 cycles: 3 stalls and 1 flush, then reset clears counters
        step(1, 0, 0, 0, 0, 0);
        adv(2);
        step(0, 1, 0, 0, 0, 0);
        adv(1);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 32'h20, 0, 0);
        adv(2);
        step(0, 1, 0, 0, 0, 0);
        adv(1);
        step(1, 0, 0, 0, 0, 0);

        // Randomized mix against the model
        for (int k = 0; k < 1024; k++) imem[k] = $urandom;
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 25),
                 ($urandom_range(0, 99) < 10),
                 $urandom,
                 ($urandom_range(0, 99) < 5),
                 ($urandom_range(0, 99) < 30));
        end

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_stage.md
INST_FETCH_STAGE -- requirements
Module: inst_fetch_stage

Interface
REQ-001 SHALL provide `clk  in  1`: the single clock; all state updates on its rising edge.
REQ-002 SHALL provide `rst  in  1`: synchronous, active-high reset.
REQ-003 SHALL provide `stall  in  1`: hold request from the decode-stage bubble output.
REQ-004 SHALL provide `flush  in  1`: redirect taken (branch or jump resolved).
REQ-005 SHALL provide `redirect_pc  in  32`: target PC, valid when flush=1.
REQ-006 SHALL provide `halt  in  1`: syscall halt request.
REQ-007 SHALL provide `resume  in  1`: leave the halted state.
REQ-008 SHALL provide `imem_addr  out  10`: instruction-memory word address, equal to pc[11:2].
REQ-009 SHALL provide `imem_data  in  32`: combinational instruction-memory read data, valid in the same cycle.
REQ-010 SHALL provide `id_inst  out  32`: registered instruction passed to decode.
REQ-011 SHALL provide `id_opcode  out  6`, `id_rt  out  5` and `id_funct  out  6`: slices [31:26], [20:16] and [5:0] of id_inst.
REQ-012 SHALL provide `id_pc4  out  32`: registered PC+4 of id_inst, used for jal link and branch targets.
REQ-013 SHALL provide `id_valid  out  1`: id_inst is a real instruction (0 = bubble).
REQ-014 SHALL provide `halted  out  1`: high while in the HALTED state.

Function
REQ-015 SHALL keep a 32-bit pc register; PC+4 SHALL wrap modulo 2^32; imem_addr SHALL wrap within the 1024-word space.
REQ-016 SHALL use a two-state FSM: RUN and HALTED.
REQ-017 Priority in RUN SHALL be: halt > flush > stall > advance.
REQ-018 Advance SHALL set pc<=pc+4, id_inst<=imem_data, id_pc4<=pc+4, id_valid<=1.
REQ-019 Stall SHALL hold pc, id_inst, id_pc4 and id_valid unchanged.
REQ-020 Flush SHALL set pc<=redirect_pc, id_inst<=0, id_valid<=0 and hold id_pc4; flush SHALL override a simultaneous stall.
REQ-021 Halt in RUN SHALL move the FSM to HALTED, hold pc, set id_inst<=0 and id_valid<=0.
REQ-022 Halt SHALL override a simultaneous flush, and the redirect SHALL be discarded.
REQ-023 In HALTED, pc and the ID register SHALL be frozen and stall/flush/halt SHALL be ignored.
REQ-024 resume=1 in HALTED SHALL return the FSM to RUN; the following cycle SHALL fetch from the frozen pc.
REQ-025 Fetch-to-decode latency SHALL be one cycle: the word at imem_addr in cycle N appears on id_inst in cycle N+1.
REQ-026 An id_inst of 0 SHALL decode as sll $0,$0,0, i.e. a NOP.

Reset
REQ-027 On rst=1 at a clock edge, the block SHALL set pc=0x00000000, id_inst=0, id_pc4=0, id_valid=0, FSM=RUN and halted=0.
REQ-028 Reset SHALL override every other input, including in the middle of a stall, flush or halt.
REQ-029 The first fetch after reset SHALL be from address 0.

Configuration
REQ-030 Macro FETCH_PERF_COUNTER_EN SHALL control the performance counters.
REQ-031 When defined, the block SHALL add three outputs: `cnt_cycle  out  32`, `cnt_stall  out  32` and `cnt_flush  out  32`.
REQ-032 cnt_cycle SHALL increment every non-HALTED cycle, cnt_stall every stall-hold cycle, and cnt_flush every accepted flush.
REQ-033 The counters SHALL wrap modulo 2^32 and SHALL clear on rst.
REQ-034 When not defined, the counter ports and logic SHALL be absent, and the remaining behaviour SHALL be identical.

Verification
REQ-035 Bench SHALL check reset then free-run with imem[k]=k+1 → id_inst=1,2,3 on cycles 1-3; id_pc4=4,8,12; id_valid=1.
REQ-036 Bench SHALL check stall=1 for 2 cycles at pc=8 → id_inst/id_pc4 held for 2 cycles; imem_addr stays 2; fetch resumes at word 2.
REQ-037 Bench SHALL check flush=1 with redirect_pc=0x40 and stall=1 together → next cycle id_valid=0, id_inst=0, imem_addr=0x10.
REQ-038 Bench SHALL check halt=1 with flush=1 → halted=1, pc unchanged, redirect ignored; resume=1 → next fetch at the held pc.
REQ-039 Bench SHALL check pc=0xFFFFFFFC advancing → pc=0 and id_pc4=0; imem_addr goes from 0x3FF to 0.
REQ-040 Bench SHALL check, with FETCH_PERF_COUNTER_EN defined, 10 cycles with 3 stalls and 1 flush → cnt_cycle=10, cnt_stall=3, cnt_flush=1; rst clears all three.
